// File: rtl/dram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_arb_pkg
// Brief    : Shared types and constants for the DRAM arbiter slice.
// Revision : 1.0
// ============================================================================
package dram_arb_pkg;

    localparam int c_N_CORES = 4;
    localparam int c_ADDR_W  = 16;
    localparam int c_DATA_W  = 8;
    localparam int c_RD_LAT  = 1;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_ACCESS = 2'd1;
    localparam state_t c_ST_WAIT   = 2'd2;
    localparam state_t c_ST_ACK    = 2'd3;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_select
// Brief    : Combinational round-robin picker (rotate, priority-encode, un-rotate).
// Revision : 1.0
// ============================================================================
module rr_select #(
    parameter int N_CORES = 4,
    parameter int ID_W    = 2
) (
    input  logic [N_CORES-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_gnt_valid,
    output logic [ID_W-1:0]    o_gnt_id
);

    localparam logic [ID_W:0] c_N = (ID_W+1)'(N_CORES);

    logic [2*N_CORES-1:0] w_req_dbl;
    logic [N_CORES-1:0]   w_rot;
    logic [ID_W-1:0]      w_idx;
    logic [ID_W:0]        w_sum;

    assign w_req_dbl = {i_req, i_req};

    // Bit 0 of w_rot corresponds to the core currently at the pointer.
    for (genvar g = 0; g < N_CORES; g++) begin : g_rot
        assign w_rot[g] = w_req_dbl[g + int'(i_ptr)];
    end

    always_comb begin
        w_idx = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, w_idx} + {1'b0, i_ptr};
        if (w_sum >= c_N) begin
            o_gnt_id = ID_W'(w_sum - c_N);
        end else begin
            o_gnt_id = ID_W'(w_sum);
        end
    end

    assign o_gnt_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_arbiter
// Brief    : Round-robin arbiter sharing one single-port DRAM among N cores.
// Revision : 1.0
// ============================================================================
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int N_CORES = c_N_CORES,
    parameter int ADDR_W  = c_ADDR_W,
    parameter int DATA_W  = c_DATA_W,
    parameter int RD_LAT  = c_RD_LAT
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_CORES-1:0]      i_req_rd,
    input  logic [N_CORES-1:0]      i_req_wr,
    input  logic [N_CORES*ADDR_W-1:0] i_req_addr,
    input  logic [N_CORES*DATA_W-1:0] i_req_wdata,
    output logic [N_CORES-1:0]      o_ack,
    output logic [DATA_W-1:0]       o_rdata,
    output logic [ADDR_W-1:0]       o_dram_addr,
    output logic                    o_dram_read,
    output logic                    o_dram_write,
    output logic [DATA_W-1:0]       o_dram_wdata,
    input  logic [DATA_W-1:0]       i_dram_rdata,
    output logic                    o_busy
);

    localparam int c_ID_W  = id_width(N_CORES);
    localparam int c_CNT_W = id_width(RD_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(RD_LAT - 1);
    localparam logic [c_ID_W-1:0]  c_LAST_ID  = c_ID_W'(N_CORES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_ID_W-1:0]     r_ptr;
    logic [c_ID_W-1:0]     r_id;
    logic                  r_is_wr;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic [c_CNT_W-1:0]    r_cnt;

    logic [N_CORES-1:0]    w_req;
    logic                  w_gnt_valid;
    logic [c_ID_W-1:0]     w_gnt_id;
    logic                  w_load;

    assign w_req = i_req_rd | i_req_wr;

    rr_select #(
        .N_CORES (N_CORES),
        .ID_W    (c_ID_W)
    ) u_rr_select (
        .i_req       (w_req),
        .i_ptr       (r_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        o_busy       = (r_state != c_ST_IDLE);
        o_dram_read  = 1'b0;
        o_dram_write = 1'b0;
        o_dram_addr  = '0;
        o_dram_wdata = '0;
        o_ack        = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                o_dram_addr  = r_addr;
                o_dram_wdata = r_wdata;
                o_dram_write = r_is_wr;
                o_dram_read  = !r_is_wr;
                w_state_nxt  = r_is_wr ? c_ST_ACK : c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_ACK;
                end
            end
            c_ST_ACK: begin
                o_ack       = N_CORES'(1) << r_id;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Request fields are captured only at grant; later input changes are ignored.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_load) begin
                r_id    <= w_gnt_id;
                r_is_wr <= i_req_wr[w_gnt_id];
                r_addr  <= i_req_addr[int'(w_gnt_id)*ADDR_W +: ADDR_W];
                r_wdata <= i_req_wdata[int'(w_gnt_id)*DATA_W +: DATA_W];
            end
            if (r_state == c_ST_ACCESS) begin
                r_cnt <= c_CNT_INIT;
            end else if ((r_state == c_ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if ((r_state == c_ST_WAIT) && (r_cnt == '0)) begin
                r_rdata <= i_dram_rdata;
            end
            if (r_state == c_ST_ACK) begin
                r_ptr <= (r_id == c_LAST_ID) ? '0 : r_id + 1'b1;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port data RAM between N_CORES matrix-multiplier cores.
- Each core presents a read or write request and holds it until acknowledged.
- The arbiter picks one core by round-robin, drives the DRAM port for exactly one access cycle, returns read data, and pulses a per-core acknowledge.
- It sits between the core array and the DRAM, replacing the direct core-to-DRAM wiring of a single-core build.

Parameters:
- N_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 16, DRAM address width.
- DATA_W, 8, DRAM data width.
- RD_LAT, 1, DRAM read latency in cycles from the read-strobe cycle to valid i_dram_rdata (1..4).

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_req_rd  in  N_CORES  per-core read request.
- i_req_wr  in  N_CORES  per-core write request.
- i_req_addr  in  N_CORES*ADDR_W  per-core address; core k occupies bits [k*ADDR_W +: ADDR_W].
- i_req_wdata  in  N_CORES*DATA_W  per-core write data, packed the same way.
- o_ack  out  N_CORES  one-cycle completion pulse to the served core.
- o_rdata  out  DATA_W  registered read data; valid in the o_ack cycle and held until the next read completes.
- o_dram_addr  out  ADDR_W  DRAM address.
- o_dram_read  out  1  DRAM read strobe.
- o_dram_write  out  1  DRAM write strobe.
- o_dram_wdata  out  DATA_W  DRAM write data.
- i_dram_rdata  in  DATA_W  DRAM read data.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - FSM goes to IDLE and the round-robin pointer goes to 0.
  - o_ack, o_dram_read, o_dram_write, o_busy, o_dram_addr, o_dram_wdata and o_rdata are all 0 from the next edge.
  - Reset mid-access aborts that access; the core gets no ack and must re-request.
- A core k is "requesting" when i_req_rd[k] | i_req_wr[k].
  - If both bits are set, the request is treated as a write.
- IDLE:
  - If any core is requesting, pick the first requesting core at or after the pointer, wrapping modulo N_CORES.
  - Register its id, operation, address and wdata, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - o_dram_addr and o_dram_wdata come from the registered request.
  - o_dram_read or o_dram_write is high for this cycle only.
  - A write goes to ACK. A read goes to WAIT with the latency counter set to RD_LAT-1.
- WAIT:
  - The counter decrements each cycle.
  - When the counter is 0, capture i_dram_rdata into o_rdata and go to ACK.
  - o_dram_read is low throughout WAIT.
- ACK (1 cycle):
  - o_ack[id] = 1, all other ack bits 0.
  - Pointer becomes (id+1) mod N_CORES.
  - Go to IDLE. No new grant is made in this cycle.
- Latency, measured from the IDLE cycle in which the request is sampled (cycle 0):
  - Write: strobe in cycle 1, ack in cycle 2, so 3 cycles per write.
  - Read: strobe in cycle 1, ack in cycle 2+RD_LAT.
- Sampling:
  - Request fields are sampled only at grant.
  - Changes to a granted core's request after grant are ignored.
  - Withdrawing after grant still completes the access and still pulses ack.
  - A request withdrawn before grant is never served.
- The core must drop or change its request in the cycle after ack. A request still asserted in the following IDLE is a new request.
- Fairness: with all cores continuously requesting, grant order is 0,1,...,N_CORES-1,0,... and no core waits more than N_CORES-1 accesses.
- o_dram_read and o_dram_write are never high together, and never high outside ACCESS.

Decomposition:
- Shared package dram_arb_pkg holds:
  - the state typedef (IDLE, ACCESS, WAIT, ACK, 2-bit encoding);
  - default parameter constants;
  - the id width function clog2(N_CORES).
- One sub-module: rr_select.
  - Combinational.
  - Inputs: request vector and pointer.
  - Outputs: grant-valid and grant-id, using a rotate, priority-encode, un-rotate scheme.
- The FSM, registers and latency counter live in dram_arbiter.

Test Plan:
- Single read, RD_LAT=1:
  - Stimulus: core 2 reads 0x1234; DRAM returns 0x5A.
  - Response: o_dram_read high exactly one cycle with addr 0x1234; o_ack[2] pulses at cycle 3; o_rdata = 0x5A.
- Simultaneous writes:
  - Stimulus: all 4 cores write; core k uses addr 0x0100+k, data 0xA0+k; each core drops its request after its ack.
  - Response: write strobes in order cores 0,1,2,3, spaced 3 cycles apart, with matching addr/data; each ack pulses once.
- Fairness:
  - Stimulus: cores 0 and 3 request continuously.
  - Response: grants alternate 0,3,0,3; core 3 never waits more than one access.
- Reset mid-read:
  - Stimulus: i_rst_n low during WAIT.
  - Response: next edge shows all outputs 0, no ack, pointer 0; after release, a pending core 1 request is served normally.
- Both request bits set:
  - Stimulus: i_req_rd[1] = i_req_wr[1] = 1 with data 0x3C.
  - Response: o_dram_write pulses with 0x3C; o_dram_read is never asserted.
- RD_LAT=3 build:
  - Stimulus: core 0 reads; i_dram_rdata = 0xC3 valid 3 cycles after the strobe.
  - Response: o_ack[0] pulses at cycle 5; o_rdata = 0xC3; o_busy high for cycles 1 through 5.
